neuron_cfg_loader_mem: RTL

NEURON_CFG_LOADER_MEM -- requirements
Module: neuron_cfg_loader_mem

---
 rtl/neuron_cfg_loader_mem.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/neuron_cfg_loader_mem.sv
// Neuron configuration store: a beat-serial loader/readback FSM in front of the
// per-neuron config banks, plus three independent registered read ports (A, B, C).
module neuron_cfg_loader_mem #(
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AXON_CNT_BIT_WIDTH = 8,
    parameter int DSIZE              = 16,
    parameter int STDP_WIN_BIT_WIDTH = 8,
    parameter int AER_BIT_WIDTH      = 32,
    parameter int CFG_BUS_WIDTH      = 32,
    parameter int AXON_WORD_WIDTH    = 64
) (
    input  logic                                           clk_i,
    input  logic                                           rst_n_i,
    input  logic [CFG_BUS_WIDTH-1:0]                       cfg_wdata_i,
    input  logic                                           cfg_valid_i,
    output logic                                           cfg_ready_o,
    output logic [CFG_BUS_WIDTH-1:0]                       cfg_rdata_o,
    output logic                                           cfg_rvalid_o,
    input  logic                                           cfg_rready_i,
    output logic                                           cfg_err_o,
    output logic                                           busy_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                  Number_Neuron_o,
    output logic [AXON_CNT_BIT_WIDTH-1:0]                  Number_Axon_o,
    input  logic [NURN_CNT_BIT_WIDTH-1:0]                  Addr_Config_A_i,
    input  logic                                           rdEn_Config_A_i,
    output logic [2*STDP_WIN_BIT_WIDTH+2*DSIZE:0]          cfg_a_o,
    input  logic [NURN_CNT_BIT_WIDTH-1:0]                  Addr_Config_B_i,
    input  logic                                           rdEn_Config_B_i,
    output logic [3*DSIZE+5:0]                             cfg_b_o,
    output logic [AER_BIT_WIDTH-1:0]                       SpikeAER_o,
    input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_Config_C_i,
    input  logic                                           rdEn_Config_C_i,
    output logic                                           axonLrnMode_o
);
    localparam int CA        = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1;
    localparam int CB        = 3*DSIZE + 6;
    localparam int N_A       = (CA + CFG_BUS_WIDTH - 1) / CFG_BUS_WIDTH;
    localparam int N_B       = (CB + CFG_BUS_WIDTH - 1) / CFG_BUS_WIDTH;
    localparam int N_E       = (AER_BIT_WIDTH + CFG_BUS_WIDTH - 1) / CFG_BUS_WIDTH;
    localparam int N_X       = (AXON_WORD_WIDTH + CFG_BUS_WIDTH - 1) / CFG_BUS_WIDTH;
    localparam int M_AB      = (N_A > N_B) ? N_A : N_B;
    localparam int M_EX      = (N_E > N_X) ? N_E : N_X;
    localparam int BEATS_MAX = (M_AB > M_EX) ? M_AB : M_EX;
    localparam int ASM_W     = BEATS_MAX * CFG_BUS_WIDTH;
    localparam int BCW       = $clog2(BEATS_MAX + 1);
    localparam int AXW       = (2**AXON_CNT_BIT_WIDTH) / AXON_WORD_WIDTH;
    localparam int WB        = $clog2(AXW);
    localparam int BB        = $clog2(AXON_WORD_WIDTH);
    localparam int DEPTH     = 2**NURN_CNT_BIT_WIDTH;

    localparam logic [3:0]     OP_WR_A = 4'h1;
    localparam logic [3:0]     OP_WR_B = 4'h2;
    localparam logic [3:0]     OP_WR_E = 4'h3;
    localparam logic [3:0]     OP_WR_X = 4'h4;
    localparam logic [3:0]     OP_WR_G = 4'h5;
    localparam logic [3:0]     OP_RD_A = 4'h9;
    localparam logic [3:0]     OP_RD_B = 4'hA;
    localparam logic [3:0]     OP_RD_E = 4'hB;
    localparam logic [3:0]     OP_RD_X = 4'hC;
    localparam logic [11:0]    AXW_L   = 12'(AXW);
    localparam logic [BCW-1:0] BC_ONE  = BCW'(1'b1);

    typedef enum logic [2:0] {ST_IDLE, ST_PAYLOAD, ST_COMMIT, ST_RDREQ, ST_RESP} state_t;

    // Read and write opcodes share the low three bits, so one lookup serves both.
    function automatic logic [BCW-1:0] beats_for(input logic [3:0] op);
        logic [BCW-1:0] n;
        case (op[2:0])
            3'd1:    n = BCW'(N_A);
            3'd2:    n = BCW'(N_B);
            3'd3:    n = BCW'(N_E);
            3'd4:    n = BCW'(N_X);
            default: n = BC_ONE;
        endcase
        return n;
    endfunction

    logic [CA-1:0]              mem_a [0:DEPTH-1];
    logic [CB-1:0]              mem_b [0:DEPTH-1];
    logic [AER_BIT_WIDTH-1:0]   mem_e [0:DEPTH-1];
    logic [AXON_WORD_WIDTH-1:0] mem_x [0:DEPTH*AXW-1];

    state_t                        state_r, state_s;
    logic [3:0]                    op_r, op_s;
    logic [11:0]                   idx_r;
    logic [NURN_CNT_BIT_WIDTH-1:0] nurn_r;
    logic [BCW-1:0]                n_beats_r, beat_cnt_r;
    logic [ASM_W-1:0]              asm_r, rd_buf_r, rd_word_s;
    logic [CFG_BUS_WIDTH-1:0]      rdata_r;
    logic                          rvalid_r, err_r, ready_r, busy_r;
    logic [NURN_CNT_BIT_WIDTH-1:0] num_neuron_r;
    logic [AXON_CNT_BIT_WIDTH-1:0] num_axon_r;
    logic                          is_wr_s, is_rd_s, beat_last_s, axon_ok_s;
    logic [CA-1:0]                 cfg_a_r;
    logic [CB-1:0]                 cfg_b_r;
    logic [AER_BIT_WIDTH-1:0]      aer_r;
    logic                          axon_lrn_r;

    // Header decode, beat bookkeeping and readback word selection.
    always_comb begin
        op_s        = cfg_wdata_i[31:28];
        is_wr_s     = 1'b0;
        is_rd_s     = 1'b0;
        beat_last_s = (beat_cnt_r == (n_beats_r - BC_ONE));
        axon_ok_s   = (idx_r < AXW_L);
        rd_word_s   = {ASM_W{1'b0}};
        if ((op_s >= OP_WR_A) && (op_s <= OP_WR_G)) begin
            is_wr_s = 1'b1;
        end else if ((op_s >= OP_RD_A) && (op_s <= OP_RD_X)) begin
            is_rd_s = 1'b1;
        end else begin
            is_wr_s = 1'b0;
        end
        case (op_r)
            OP_RD_A: rd_word_s = ASM_W'(mem_a[nurn_r]);
            OP_RD_B: rd_word_s = ASM_W'(mem_b[nurn_r]);
            OP_RD_E: rd_word_s = ASM_W'(mem_e[nurn_r]);
            OP_RD_X: begin
                if (axon_ok_s) begin
                    rd_word_s = ASM_W'(mem_x[{nurn_r, idx_r[WB-1:0]}]);
                end else begin
                    rd_word_s = {ASM_W{1'b0}};
                end
            end
            default: rd_word_s = {ASM_W{1'b0}};
        endcase
    end

    // Loader state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Loader next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_valid_i && is_wr_s) begin
                    state_s = ST_PAYLOAD;
                end else if (cfg_valid_i && is_rd_s) begin
                    state_s = ST_RDREQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (cfg_valid_i && beat_last_s) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            ST_RDREQ:  state_s = ST_RESP;
            ST_RESP: begin
                if (cfg_rready_i && beat_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default:   state_s = ST_IDLE;
        endcase
    end

    // Loader datapath: header capture, payload assembly, readback shifting, flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_r         <= 4'h0;
            idx_r        <= 12'h000;
            nurn_r       <= {NURN_CNT_BIT_WIDTH{1'b0}};
            n_beats_r    <= BC_ONE;
            beat_cnt_r   <= {BCW{1'b0}};
            asm_r        <= {ASM_W{1'b0}};
            rd_buf_r     <= {ASM_W{1'b0}};
            rdata_r      <= {CFG_BUS_WIDTH{1'b0}};
            rvalid_r     <= 1'b0;
            err_r        <= 1'b0;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            num_neuron_r <= {NURN_CNT_BIT_WIDTH{1'b0}};
            num_axon_r   <= {AXON_CNT_BIT_WIDTH{1'b0}};
        end else begin
            ready_r <= (state_s == ST_IDLE) || (state_s == ST_PAYLOAD);
            busy_r  <= (state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (cfg_valid_i) begin
                        op_r       <= op_s;
                        idx_r      <= cfg_wdata_i[27:16];
                        nurn_r     <= cfg_wdata_i[NURN_CNT_BIT_WIDTH-1:0];
                        n_beats_r  <= beats_for(op_s);
                        beat_cnt_r <= {BCW{1'b0}};
                        if (!is_wr_s && !is_rd_s) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (cfg_valid_i) begin
                        asm_r[beat_cnt_r*CFG_BUS_WIDTH +: CFG_BUS_WIDTH] <= cfg_wdata_i;
                        beat_cnt_r <= beat_last_s ? {BCW{1'b0}} : (beat_cnt_r + BC_ONE);
                    end
                end
                ST_COMMIT: begin
                    case (op_r)
                        OP_WR_X: begin
                            if (!axon_ok_s) begin
                                err_r <= 1'b1;
                            end
                        end
                        OP_WR_G: begin
                            num_axon_r   <= asm_r[AXON_CNT_BIT_WIDTH-1:0];
                            num_neuron_r <= asm_r[AXON_CNT_BIT_WIDTH+NURN_CNT_BIT_WIDTH-1:AXON_CNT_BIT_WIDTH];
                        end
                        default: ;
                    endcase
                end
                ST_RDREQ: begin
                    rdata_r    <= rd_word_s[CFG_BUS_WIDTH-1:0];
                    rd_buf_r   <= rd_word_s >> CFG_BUS_WIDTH;
                    rvalid_r   <= 1'b1;
                    beat_cnt_r <= {BCW{1'b0}};
                    if ((op_r == OP_RD_X) && !axon_ok_s) begin
                        err_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (cfg_rready_i) begin
                        if (beat_last_s) begin
                            rvalid_r <= 1'b0;
                            rdata_r  <= {CFG_BUS_WIDTH{1'b0}};
                        end else begin
                            rdata_r    <= rd_buf_r[CFG_BUS_WIDTH-1:0];
                            rd_buf_r   <= rd_buf_r >> CFG_BUS_WIDTH;
                            beat_cnt_r <= beat_cnt_r + BC_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Single-cycle commit of the assembled payload into the addressed bank.
    always_ff @(posedge clk_i) begin
        if (state_r == ST_COMMIT) begin
            case (op_r)
                OP_WR_A: mem_a[nurn_r] <= asm_r[CA-1:0];
                OP_WR_B: mem_b[nurn_r] <= asm_r[CB-1:0];
                OP_WR_E: mem_e[nurn_r] <= asm_r[AER_BIT_WIDTH-1:0];
                OP_WR_X: begin
                    if (axon_ok_s) begin
                        mem_x[{nurn_r, idx_r[WB-1:0]}] <= asm_r[AXON_WORD_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Independent read ports; non-blocking reads give read-first against a commit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_a_r    <= {CA{1'b0}};
            cfg_b_r    <= {CB{1'b0}};
            aer_r      <= {AER_BIT_WIDTH{1'b0}};
            axon_lrn_r <= 1'b0;
        end else begin
            if (rdEn_Config_A_i) begin
                cfg_a_r <= mem_a[Addr_Config_A_i];
            end
            if (rdEn_Config_B_i) begin
                cfg_b_r <= mem_b[Addr_Config_B_i];
                aer_r   <= mem_e[Addr_Config_B_i];
            end
            if (rdEn_Config_C_i) begin
                axon_lrn_r <= mem_x[{Addr_Config_C_i[NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:AXON_CNT_BIT_WIDTH],
                                     Addr_Config_C_i[AXON_CNT_BIT_WIDTH-1:BB]}][Addr_Config_C_i[BB-1:0]];
            end
        end
    end

    assign cfg_ready_o     = ready_r;
    assign cfg_rdata_o     = rdata_r;
    assign cfg_rvalid_o    = rvalid_r;
    assign cfg_err_o       = err_r;
    assign busy_o          = busy_r;
    assign Number_Neuron_o = num_neuron_r;
    assign Number_Axon_o   = num_axon_r;
    assign cfg_a_o         = cfg_a_r;
    assign cfg_b_o         = cfg_b_r;
    assign SpikeAER_o      = aer_r;
    assign axonLrnMode_o   = axon_lrn_r;
endmodule
